// File: rtl/mem_lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and byte-count helper shared by the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return s == SIZE_B ? 3'd1 : s == SIZE_H ? 3'd2 : s == SIZE_W ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: core-side request/response handshake of the load/store unit.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_lsu_load_align.sv
// lsu_load_align: shifts the {hi,lo} read pair down by the byte offset and sign/zero-extends.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] r64_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);
  logic [31:0] x;
  always_comb begin
    x = 32'(r64_i >> {off_i, 3'b000});
    data_o = size_i == SIZE_B ? {{24{~uns_i & x[7]}}, x[7:0]} :
             size_i == SIZE_H ? {{16{~uns_i & x[15]}}, x[15:0]} : x;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator on a word memory port; splits word-crossing accesses into two words.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mem_lsu_if.slave         core,
  output logic [31:0]      mem_addr_o,
  output logic             mem_rstrb_o,
  input  logic [31:0]      mem_rdata_i,
  output logic [3:0]       mem_wmask_o,
  output logic [31:0]      mem_wdata_o
);
  state_e      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, lo_q;
  logic        req_err, split;
  logic [2:0]  n;
  logic [7:0]  m8;
  logic [31:0] wm, word0, ld;
  logic [63:0] d64, r64;
  lsu_load_align u_align (
    .r64_i  (r64),
    .off_i  (addr_q[1:0]),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (ld)
  );
  always_comb begin
    req_err = core.req_size == SIZE_ILL ||
              (!ALLOW_MISALIGNED && ((core.req_size == SIZE_H && core.req_addr[0]) ||
                                     (core.req_size == SIZE_W && |core.req_addr[1:0])));
    n       = size_bytes(size_q);
    m8      = ((8'd1 << n) - 8'd1) << addr_q[1:0];
    split   = |m8[7:4];
    word0   = {addr_q[31:2], 2'b00};
    // unused lanes of narrow stores are forced to zero before lane shifting
    wm      = size_q == SIZE_B ? {24'd0, wdata_q[7:0]} :
              size_q == SIZE_H ? {16'd0, wdata_q[15:0]} : wdata_q;
    d64     = {32'd0, wm} << {addr_q[1:0], 3'b000};
    r64     = split ? {mem_rdata_i, lo_q} : {32'd0, mem_rdata_i};
    state_d = state_q == IDLE ? (core.req_valid ? (req_err ? RESP : ACC0) : IDLE) :
              state_q == ACC0 ? (split ? ACC1 : RESP) :
              state_q == ACC1 ? RESP : IDLE;
    core.req_ready  = state_q == IDLE;
    core.resp_valid = state_q == RESP;
    core.resp_err   = state_q == RESP && err_q;
    core.resp_rdata = state_q == RESP && !we_q && !err_q ? ld : 32'd0;
    mem_addr_o  = state_q == ACC0 ? word0 : state_q == ACC1 ? word0 + 32'd4 : 32'd0;
    mem_rstrb_o = (state_q == ACC0 || state_q == ACC1) && !we_q;
    mem_wmask_o = !we_q ? 4'd0 : state_q == ACC0 ? m8[3:0] : state_q == ACC1 ? m8[7:4] : 4'd0;
    mem_wdata_o = !we_q ? 32'd0 : state_q == ACC0 ? d64[31:0] : state_q == ACC1 ? d64[63:32] : 32'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && core.req_valid) begin
        we_q    <= core.req_we;
        uns_q   <= core.req_unsigned;
        err_q   <= req_err;
        size_q  <= core.req_size;
        addr_q  <= core.req_addr;
        wdata_q <= core.req_wdata;
      end
      if (state_q == ACC1) lo_q <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with misaligned accesses enabled and disabled.
module tb_mem_lsu;
  import lsu_pkg::*;
  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  exp_t sb[$];
  logic [68:0] trq[$];
  always #5 clk = ~clk;
  mem_lsu_if i1();
  mem_lsu_if i2();
  logic [31:0] a1, a2, wd1, wd2;
  logic [31:0] rd1 = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic        rs1, rs2;
  logic [3:0]  wm1, wm2;
  logic [31:0] mem1 [256] = '{default: 32'd0};
  logic [31:0] mem2 [256] = '{0: 32'h80FF1234, default: 32'd0};
  mem_lsu #(.ALLOW_MISALIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .core(i1.slave), .mem_addr_o(a1), .mem_rstrb_o(rs1),
    .mem_rdata_i(rd1), .mem_wmask_o(wm1), .mem_wdata_o(wd1)
  );
  mem_lsu #(.ALLOW_MISALIGNED(1'b0)) u2 (
    .clk(clk), .rst(rst), .core(i2.slave), .mem_addr_o(a2), .mem_rstrb_o(rs2),
    .mem_rdata_i(rd2), .mem_wmask_o(wm2), .mem_wdata_o(wd2)
  );
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wm1[b]) mem1[a1[9:2]][8*b +: 8] <= wd1[8*b +: 8];
      if (wm2[b]) mem2[a2[9:2]][8*b +: 8] <= wd2[8*b +: 8];
    end
    if (rs1) rd1 <= mem1[a1[9:2]];
    if (rs2) rd2 <= mem2[a2[9:2]];
  end
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // memory-port monitor: logs every access and checks the bus is quiet otherwise
  always @(negedge clk) begin
    if (rs1 || wm1 != 4'd0) begin
      chk("excl1", {95'd0, rs1 && wm1 != 4'd0}, 96'd0);
      trq.push_back({a1, rs1, wm1, wd1});
    end else chk("idle_bus1", {32'd0, a1, wd1}, 96'd0);
    if (rs2 || wm2 != 4'd0) begin
      chk("excl2", {95'd0, rs2 && wm2 != 4'd0}, 96'd0);
      trq.push_back({a2, rs2, wm2, wd2});
    end else chk("idle_bus2", {32'd0, a2, wd2}, 96'd0);
  end
  task automatic tchk(input int i, input logic [31:0] a, input logic r, input logic [3:0] m,
                      input logic [31:0] d);
    logic [68:0] g;
    g = i < trq.size() ? trq[i] : '1;
    chk($sformatf("traffic%0d", i), {27'd0, g}, {27'd0, a, r, m, d});
  endtask
  task automatic drive(input bit sel, input bit v, input bit we, input logic [31:0] a,
                       input logic [1:0] sz, input bit u, input logic [31:0] wd);
    if (sel) begin
      i2.req_valid = v; i2.req_we = we; i2.req_addr = a;
      i2.req_size = sz; i2.req_unsigned = u; i2.req_wdata = wd;
    end else begin
      i1.req_valid = v; i1.req_we = we; i1.req_addr = a;
      i1.req_size = sz; i1.req_unsigned = u; i1.req_wdata = wd;
    end
  endtask
  function automatic logic rv(input bit sel);
    return sel ? i2.resp_valid : i1.resp_valid;
  endfunction
  task automatic req(input bit sel, input bit we, input logic [31:0] a, input logic [1:0] sz,
                     input bit u, input logic [31:0] wd, input logic [31:0] er, input bit ee,
                     input int el);
    int lat;
    exp_t e;
    @(negedge clk);
    trq.delete();
    chk("ready", {95'd0, sel ? i2.req_ready : i1.req_ready}, 96'd1);
    drive(sel, 1'b1, we, a, sz, u, wd);
    sb.push_back('{er, ee, el});
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv(sel) && lat < 8);
    e = sb.pop_front();
    chk("latency", 96'(lat), 96'(e.lat));
    chk("rdata", {64'd0, sel ? i2.resp_rdata : i1.resp_rdata}, {64'd0, e.rdata});
    chk("err", {95'd0, sel ? i2.resp_err : i1.resp_err}, {95'd0, e.err});
    @(negedge clk);
    chk("pulse", {95'd0, rv(sel)}, 96'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("rst_ready", {95'd0, i1.req_ready}, 96'd1);
    chk("rst_resp", {62'd0, i1.resp_valid, i1.resp_err, i1.resp_rdata}, 96'd0);
    chk("rst_mem", {27'd0, a1, rs1, wm1, wd1}, 96'd0);
    rst = 1'b0;
    req(0, 1, 32'h10, SIZE_W, 0, 32'hDEADBEEF, 32'd0, 0, 2);
    chk("ntr_sw", 96'(trq.size()), 96'd1);
    tchk(0, 32'h10, 0, 4'b1111, 32'hDEADBEEF);
    req(0, 1, 32'h13, SIZE_B, 0, 32'h123456A5, 32'd0, 0, 2);
    tchk(0, 32'h10, 0, 4'b1000, 32'hA5000000);
    req(0, 0, 32'h13, SIZE_B, 0, 32'd0, 32'hFFFFFFA5, 0, 2);
    tchk(0, 32'h10, 1, 4'b0000, 32'd0);
    req(0, 0, 32'h13, SIZE_B, 1, 32'd0, 32'h000000A5, 0, 2);
    req(0, 1, 32'h0, SIZE_W, 0, 32'h44332211, 32'd0, 0, 2);
    req(0, 1, 32'h4, SIZE_W, 0, 32'h88776655, 32'd0, 0, 2);
    req(0, 0, 32'h3, SIZE_W, 0, 32'd0, 32'h77665544, 0, 3);
    chk("ntr_lw_split", 96'(trq.size()), 96'd2);
    tchk(0, 32'h0, 1, 4'b0000, 32'd0);
    tchk(1, 32'h4, 1, 4'b0000, 32'd0);
    req(0, 1, 32'h7, SIZE_H, 0, 32'hFFFFBEEF, 32'd0, 0, 3);
    tchk(0, 32'h4, 0, 4'b1000, 32'hEF000000);
    tchk(1, 32'h8, 0, 4'b0001, 32'h000000BE);
    req(0, 0, 32'h7, SIZE_H, 0, 32'd0, 32'hFFFFBEEF, 0, 3);
    req(0, 0, 32'h7, SIZE_H, 1, 32'd0, 32'h0000BEEF, 0, 3);
    req(0, 0, 32'h1, SIZE_H, 0, 32'd0, 32'h00003322, 0, 2);
    req(0, 0, 32'h10, SIZE_ILL, 0, 32'd0, 32'd0, 1, 1);
    chk("ntr_ill_ld", 96'(trq.size()), 96'd0);
    req(0, 1, 32'h10, SIZE_ILL, 0, 32'h12345678, 32'd0, 1, 1);
    chk("ntr_ill_st", 96'(trq.size()), 96'd0);
    req(0, 1, 32'hFFFFFFFC, SIZE_W, 0, 32'hCAFEF00D, 32'd0, 0, 2);
    tchk(0, 32'hFFFFFFFC, 0, 4'b1111, 32'hCAFEF00D);
    req(0, 0, 32'hFFFFFFFE, SIZE_W, 0, 32'd0, 32'h2211CAFE, 0, 3);
    tchk(0, 32'hFFFFFFFC, 1, 4'b0000, 32'd0);
    tchk(1, 32'h0, 1, 4'b0000, 32'd0);
    req(1, 0, 32'h1, SIZE_H, 0, 32'd0, 32'd0, 1, 1);
    chk("ntr_mis_h", 96'(trq.size()), 96'd0);
    req(1, 0, 32'h2, SIZE_W, 0, 32'd0, 32'd0, 1, 1);
    chk("ntr_mis_w", 96'(trq.size()), 96'd0);
    req(1, 0, 32'h2, SIZE_H, 0, 32'd0, 32'hFFFF80FF, 0, 2);
    tchk(0, 32'h0, 1, 4'b0000, 32'd0);
    req(1, 0, 32'h3, SIZE_B, 1, 32'd0, 32'h00000080, 0, 2);
    // reset in the second half of a split store: only the low word is written
    @(negedge clk);
    drive(0, 1, 1, 32'h21, SIZE_W, 0, 32'hAABBCCDD);
    @(posedge clk);
    #1 drive(0, 0, 0, 32'd0, 2'd0, 0, 32'd0);
    @(negedge clk);
    chk("acc0_st", {27'd0, a1, rs1, wm1, wd1}, {27'd0, 32'h20, 1'b0, 4'b1110, 32'hBBCCDD00});
    @(negedge clk);
    chk("acc1_st", {27'd0, a1, rs1, wm1, wd1}, {27'd0, 32'h24, 1'b0, 4'b0001, 32'h000000AA});
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {95'd0, i1.req_ready}, 96'd1);
    chk("mid_rst_mem", {27'd0, a1, rs1, wm1, wd1}, 96'd0);
    chk("mid_rst_resp", {95'd0, i1.resp_valid}, 96'd0);
    @(negedge clk);
    rst = 1'b0;
    req(0, 0, 32'h20, SIZE_W, 0, 32'd0, 32'hBBCCDD00, 0, 2);
    req(0, 0, 32'h24, SIZE_W, 0, 32'd0, 32'h00000000, 0, 2);
    chk("sb_empty", 96'(sb.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
